// File: rtl/pipe_hazard_ctrl_if.sv
// ID-to-issue handshake bundle for pipe_hazard_ctrl.
// The master side drives the ID instruction and flush. The slave side returns stall, issue, forwarding selects and debug state.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
) ();

  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             id_we;
  logic             flush;
  logic             stall;
  logic             issue;
  logic [1:0]       ex_fwd_a;
  logic [1:0]       ex_fwd_b;
  logic [31:0]      busy_mask;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_we, flush,
    input  stall, issue, ex_fwd_a, ex_fwd_b, busy_mask, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_we, flush,
    output stall, issue, ex_fwd_a, ex_fwd_b, busy_mask, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Issue-stage hazard scheduler: a shift scoreboard of in-flight RF writes decides issue/stall between ID and EX.
// Define HAZ_FWD_EN to add registered EX forwarding selects; this also shrinks the stall window to slots >= 3.
module pipe_hazard_ctrl #(
  parameter int WB_LAT    = 3,
  parameter int RF_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  // Slots in hazard window: HAZ_LO..HAZ_HI (empty when HAZ_LO > HAZ_HI)
  localparam int HAZ_HI = (RF_BYPASS != 0) ? WB_LAT - 2 : WB_LAT - 1;
`ifdef HAZ_FWD_EN
  localparam int HAZ_LO = 3;
`else
  localparam int HAZ_LO = 0;
`endif

  logic [WB_LAT-1:0] slotV;
  logic [4:0]        slotRd [WB_LAT];
  logic [WB_LAT-1:0] matchA;
  logic [WB_LAT-1:0] matchB;
  logic [WB_LAT-1:0] winMask;
  logic              hazard;
  logic              stallInt;
  logic              issueInt;
  logic              slot0Load;
  logic [31:0]       busyMask;
  logic [CNT_W-1:0]  stallCnt;

  // Per-slot source matches; R0 is never a dependency
  generate
    for (genvar gi = 0; gi < WB_LAT; gi++) begin : g_match
      assign matchA[gi]  = slotV[gi] && (slotRd[gi] == bus.id_rs) && (bus.id_rs != 5'd0);
      assign matchB[gi]  = slotV[gi] && (slotRd[gi] == bus.id_rt) && (bus.id_rt != 5'd0);
      assign winMask[gi] = ((gi >= HAZ_LO) && (gi <= HAZ_HI)) ? 1'b1 : 1'b0;
    end
  endgenerate

  assign hazard    = |((matchA | matchB) & winMask);
  assign stallInt  = bus.id_valid && !bus.flush && hazard;
  assign issueInt  = bus.id_valid && !bus.flush && !stallInt;
  assign slot0Load = issueInt && bus.id_we && (bus.id_rd != 5'd0);

  always_comb begin
    busyMask = '0;
    for (int i = 0; i < WB_LAT; i++) begin
      if (slotV[i]) begin
        busyMask[slotRd[i]] = 1'b1;
      end
    end
  end

  // Scoreboard shift: stall and flush both put a bubble into slot0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slotV <= '0;
      for (int i = 0; i < WB_LAT; i++) begin
        slotRd[i] <= 5'd0;
      end
    end else if (bus.flush) begin
      slotV <= '0;
      for (int i = 0; i < WB_LAT; i++) begin
        slotRd[i] <= 5'd0;
      end
    end else begin
      slotV[0]  <= slot0Load;
      slotRd[0] <= slot0Load ? bus.id_rd : 5'd0;
      for (int i = 1; i < WB_LAT; i++) begin
        slotV[i]  <= slotV[i-1];
        slotRd[i] <= slotRd[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (stallInt && (stallCnt != {CNT_W{1'b1}})) begin
      stallCnt <= stallCnt + 1'b1;
    end
  end

`ifdef HAZ_FWD_EN
  logic [1:0] fwdAReg;
  logic [1:0] fwdBReg;

  // Youngest slot wins; the WB slot is only forwarded when the RF is not write-first
  function automatic logic [1:0] fwdSel(input logic [WB_LAT-1:0] m);
    logic [7:0] p;
    p = 8'(m);
    if (p[0])                          return 2'b01;
    else if (p[1])                     return 2'b10;
    else if (p[2] && (RF_BYPASS == 0)) return 2'b11;
    else                               return 2'b00;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwdAReg <= 2'b00;
      fwdBReg <= 2'b00;
    end else if (issueInt) begin
      fwdAReg <= fwdSel(matchA);
      fwdBReg <= fwdSel(matchB);
    end else begin
      fwdAReg <= 2'b00;
      fwdBReg <= 2'b00;
    end
  end

  assign bus.ex_fwd_a = fwdAReg;
  assign bus.ex_fwd_b = fwdBReg;
`else
  assign bus.ex_fwd_a = 2'b00;
  assign bus.ex_fwd_b = 2'b00;
`endif

  assign bus.stall     = stallInt;
  assign bus.issue     = issueInt;
  assign bus.busy_mask = busyMask;
  assign bus.stall_cnt = stallCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised scoreboard bench for pipe_hazard_ctrl; model tracks the last issue cycle of every register.
module tb_pipe_hazard_ctrl;

  localparam int WB_LAT    = 3;
  localparam int RF_BYPASS = 1;
  localparam int CNT_W     = 10;
  localparam int CMAX      = (1 << CNT_W) - 1;
  localparam int HI = (RF_BYPASS != 0) ? WB_LAT - 2 : WB_LAT - 1;
`ifdef HAZ_FWD_EN
  localparam int LO = 3;
`else
  localparam int LO = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.WB_LAT(WB_LAT), .RF_BYPASS(RF_BYPASS), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        stall;
    logic        issue;
    logic [31:0] busy;
    logic [1:0]  fa;
    logic [1:0]  fb;
    int          cnt;
  } exp_t;

  exp_t q[$];
  int   nTests = 0;
  int   nFail  = 0;

  // Model state: cycle of latest issue writing each register
  int   cyc = 0;
  int   lastWr [32];
  logic [1:0] mFa = 2'b00;
  logic [1:0] mFb = 2'b00;
  int   mCnt = 0;
  logic lastStallExp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nTests++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int ageOf(input logic [4:0] r);
    return cyc - lastWr[r] - 1;
  endfunction

  function automatic logic hazardOn(input logic [4:0] r);
    int a;
    a = ageOf(r);
    return (r != 5'd0) && (a >= LO) && (a <= HI);
  endfunction

  function automatic logic [1:0] selOf(input logic [4:0] r);
    int a;
    a = ageOf(r);
    if (r == 5'd0 || a > WB_LAT - 1) return 2'b00;
    if (a == 0) return 2'b01;
    if (a == 1) return 2'b10;
    if (a == 2 && RF_BYPASS == 0) return 2'b11;
    return 2'b00;
  endfunction

  task automatic clearModel();
    for (int r = 0; r < 32; r++) lastWr[r] = -1000;
    mFa = 2'b00;
    mFb = 2'b00;
  endtask

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic we, input logic fl);
    exp_t e;
    e.stall = v && !fl && (hazardOn(rs) || hazardOn(rt));
    e.issue = v && !fl && !e.stall;
    e.busy  = '0;
    for (int r = 1; r < 32; r++) begin
      if (ageOf(5'(r)) <= WB_LAT - 1) e.busy[r] = 1'b1;
    end
    e.fa  = mFa;
    e.fb  = mFb;
    e.cnt = mCnt;
    q.push_back(e);
    lastStallExp = e.stall;
    if (fl) begin
      clearModel();
    end else begin
`ifdef HAZ_FWD_EN
      mFa = e.issue ? selOf(rs) : 2'b00;
      mFb = e.issue ? selOf(rt) : 2'b00;
`endif
      if (e.issue && we && rd != 5'd0) lastWr[rd] = cyc;
    end
    if (e.stall && mCnt != CMAX) mCnt++;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic we, input logic fl);
    @(posedge clk);
    #1;
    bus.id_valid = v;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_rd    = rd;
    bus.id_we    = we;
    bus.flush    = fl;
    step(v, rs, rt, rd, we, fl);
  endtask

  // Holds the instruction in ID until the model says it issued
  task automatic issueInstr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, rs, rt, rd, 1'b1, 1'b0);
      if (!lastStallExp) break;
    end
  endtask

  task automatic randPhase(input int n);
    logic [4:0] rs, rt, rd;
    logic v, we, fl;
    rs = 0; rt = 0; rd = 0; v = 0; we = 0;
    for (int k = 0; k < n; k++) begin
      if (!lastStallExp) begin
        v  = ($urandom_range(0, 99) < 85);
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        we = ($urandom_range(0, 3) != 0);
      end
      fl = ($urandom_range(0, 99) < 5);
      drive(v, rs, rt, rd, we, fl);
    end
  endtask

  // Monitor: one transaction line per compared cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("stall", 32'(bus.stall), 32'(e.stall));
      chk("issue", 32'(bus.issue), 32'(e.issue));
      chk("busy_mask", bus.busy_mask, e.busy);
      chk("ex_fwd_a", 32'(bus.ex_fwd_a), 32'(e.fa));
      chk("ex_fwd_b", 32'(bus.ex_fwd_b), 32'(e.fb));
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(e.cnt));
      $display("[TB] t=%0t v=%0b rs=%0d rt=%0d rd=%0d fl=%0b -> stall=%0b issue=%0b busy=%08h fa=%0d fb=%0d cnt=%0d",
               $time, bus.id_valid, bus.id_rs, bus.id_rt, bus.id_rd, bus.flush,
               bus.stall, bus.issue, bus.busy_mask, bus.ex_fwd_a, bus.ex_fwd_b, bus.stall_cnt);
    end
  end

  task automatic checkZeroOutputs(input string tag);
    chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    chk({tag, "_busy"}, bus.busy_mask, 32'd0);
    chk({tag, "_fwd_a"}, 32'(bus.ex_fwd_a), 32'd0);
    chk({tag, "_fwd_b"}, 32'(bus.ex_fwd_b), 32'd0);
    chk({tag, "_cnt"}, 32'(bus.stall_cnt), 32'd0);
  endtask

  initial begin
    bus.id_valid = 1'b0;
    bus.id_rs    = 5'd0;
    bus.id_rt    = 5'd0;
    bus.id_rd    = 5'd0;
    bus.id_we    = 1'b0;
    bus.flush    = 1'b0;
    clearModel();
    #2;
    checkZeroOutputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Independent stream, then dependent pair, then gap of one
    issueInstr(5'd2, 5'd3, 5'd1);
    issueInstr(5'd5, 5'd6, 5'd4);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    issueInstr(5'd7, 5'd3, 5'd1);
    issueInstr(5'd1, 5'd3, 5'd2);
    issueInstr(5'd4, 5'd4, 5'd8);
    issueInstr(5'd8, 5'd8, 5'd9);
    issueInstr(5'd6, 5'd6, 5'd10);
    issueInstr(5'd9, 5'd9, 5'd11);
    repeat (3) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // R0 destination/sources are ignored
    issueInstr(5'd1, 5'd1, 5'd0);
    issueInstr(5'd0, 5'd0, 5'd2);
    repeat (3) drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // Producer r5, stalled consumer, flush
    issueInstr(5'd1, 5'd1, 5'd5);
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b1);
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    randPhase(600);

    // Dependent chain drives stall_cnt into saturation
    for (int k = 0; k < 560; k++) issueInstr(5'd1, 5'd1, 5'd1);
    randPhase(100);

    // Asynchronous reset mid-stream
    issueInstr(5'd3, 5'd3, 5'd3);
    drive(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    bus.id_valid = 1'b1;
    bus.id_rs    = 5'd4;
    bus.id_rt    = 5'd3;
    rst = 1'b1;
    #1;
    checkZeroOutputs("midrst");
    bus.id_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
    mCnt = 0;
    lastStallExp = 1'b0;

    randPhase(300);
    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
